// File: rtl/alu_pkg.sv
// Shared definitions for the ALU frame controller and the ALU itself:
// opcode encodings, the error reply byte, the FSM state type and the opcode check.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W-1:0] OP_AND = 6'h24;
  localparam logic [OP_W-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W-1:0] OP_SRL = 6'h02;
  localparam logic [OP_W-1:0] OP_NOR = 6'h27;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND_LO,
    WAIT_LO,
    SEND_HI,
    WAIT_HI,
    SEND_ERR,
    WAIT_ERR
  } state_t;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_timer.sv
// Inter-byte timeout counter: counts while i_run is high, restarts on i_clear,
// and flags o_expired on the cycle the count reaches TIMEOUT_CYCLES-1.
module alu_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;

  // A byte arriving on the terminal cycle wins over the timeout.
  assign o_expired = i_run && !i_clear && (count_q == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !i_run || o_expired) count_q <= '0;
    else                                           count_q <= count_q + CW'(1);
  end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Frame sequencer between UART RX/TX and alu_logic: A, B, opcode in; result
// out as low byte then high byte. Optional timeout under ALU_CTRL_TIMEOUT_EN.
module alu_frame_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_CODE_SIZE   = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_done,
  input  logic                    i_tx_done,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_start,
  output logic [DATA_WIDTH-1:0]   o_dato_a,
  output logic [DATA_WIDTH-1:0]   o_dato_b,
  output logic [OP_CODE_SIZE-1:0] o_op_code,
  input  logic [DATA_WIDTH:0]     i_resultado,
  output logic                    o_error,
  output logic                    o_overrun,
  output logic                    o_timeout
);

  state_t                  state;
  logic                    result_hi_q;
  logic [OP_CODE_SIZE-1:0] op_field;
  logic                    rx_accept;
  logic                    timer_expired;

  assign op_field  = i_rx_data[OP_CODE_SIZE-1:0];
  assign rx_accept = i_rx_done && (state inside {WAIT_A, WAIT_B, WAIT_OP});

`ifdef ALU_CTRL_TIMEOUT_EN
  logic timeout_q;

  alu_ctrl_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (rx_accept),
    .i_run    (state inside {WAIT_B, WAIT_OP}),
    .o_expired(timer_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) timeout_q <= 1'b0;
    else         timeout_q <= timer_expired;
  end

  assign o_timeout = timeout_q;
`else
  assign timer_expired = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  // o_tx_start is raised on entry to each SEND_* state so it is high during
  // that state; the low result byte goes straight into o_tx_data at EXEC.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments only, so every branch reads pre-edge state.
    if (i_reset) begin
      state       <= WAIT_A;
      o_dato_a    <= '0;
      o_dato_b    <= '0;
      o_op_code   <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_error     <= 1'b0;
      o_overrun   <= 1'b0;
      result_hi_q <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      if (i_rx_done && !rx_accept) o_overrun <= 1'b1;

      unique case (state)
        WAIT_A: if (i_rx_done) begin
          o_dato_a <= DATA_WIDTH'(i_rx_data);
          state    <= WAIT_B;
        end
        WAIT_B: begin
          if (i_rx_done) begin
            o_dato_b <= DATA_WIDTH'(i_rx_data);
            state    <= WAIT_OP;
          end else if (timer_expired) begin
            state <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            if (is_valid_op(op_field)) begin
              o_op_code <= op_field;
              state     <= EXEC;
            end else begin
              o_error    <= 1'b1;
              o_tx_data  <= ERR_BYTE;
              o_tx_start <= 1'b1;
              state      <= SEND_ERR;
            end
          end else if (timer_expired) begin
            state <= WAIT_A;
          end
        end
        EXEC: begin
          result_hi_q <= i_resultado[DATA_WIDTH];
          o_tx_data   <= i_resultado[7:0];
          o_tx_start  <= 1'b1;
          state       <= SEND_LO;
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: if (i_tx_done) begin
          o_tx_data  <= {7'b0, result_hi_q};
          o_tx_start <= 1'b1;
          state      <= SEND_HI;
        end
        SEND_HI:  state <= WAIT_HI;
        WAIT_HI:  if (i_tx_done) state <= WAIT_A;
        SEND_ERR: state <= WAIT_ERR;
        WAIT_ERR: if (i_tx_done) state <= WAIT_A;
        default:  state <= WAIT_A;
      endcase
    end
  end

endmodule

// File: doc/alu_frame_ctrl.md
Name: alu_frame_ctrl

Overview:
Sequencer between a byte-oriented serial link (UART RX/TX cores) and the combinational ALU alu_logic.
- Collects a 3-byte command frame in order: operand A, operand B, opcode.
- Drives the ALU operand and opcode inputs and registers the 9-bit result.
- Returns the result as two bytes over TX.
- Rejects opcodes the ALU does not implement.

Parameters:
- DATA_WIDTH, 8, operand width; the ALU result width is DATA_WIDTH+1.
- OP_CODE_SIZE, 6, opcode width; taken from bits [OP_CODE_SIZE-1:0] of the opcode byte.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clock cycles; used only with ALU_CTRL_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock. This is the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte; valid only while i_rx_done is high.
- i_rx_done  in  1  one-cycle pulse: new RX byte.
- i_tx_done  in  1  one-cycle pulse: TX core finished the current byte.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data.
- o_dato_a  out  DATA_WIDTH  ALU operand A.
- o_dato_b  out  DATA_WIDTH  ALU operand B.
- o_op_code  out  OP_CODE_SIZE  ALU opcode.
- i_resultado  in  DATA_WIDTH+1  ALU result.
- o_error  out  1  one-cycle pulse: invalid opcode received.
- o_overrun  out  1  sticky flag: RX byte dropped.
- o_timeout  out  1  one-cycle pulse: frame aborted by timeout.

Behaviour:
- Interface: one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset values: state = WAIT_A; o_dato_a, o_dato_b, o_tx_data = 0; o_op_code = 0; o_tx_start, o_error, o_overrun, o_timeout = 0. Reset asserted mid-frame or mid-transmit aborts immediately; no partial frame survives.
- State machine: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND_LO -> WAIT_LO -> SEND_HI -> WAIT_HI -> WAIT_A.
- WAIT_A, WAIT_B: on i_rx_done, latch i_rx_data into o_dato_a or o_dato_b, then advance.
- WAIT_OP: on i_rx_done, check i_rx_data[OP_CODE_SIZE-1:0] against the valid set {0x20, 0x22, 0x24, 0x25, 0x26, 0x03, 0x02, 0x27}.
  - Valid: latch into o_op_code, go to EXEC.
  - Invalid: o_op_code is not updated; pulse o_error; o_tx_data = 0xEE; go to SEND_ERR.
  - Bits above OP_CODE_SIZE are ignored.
- EXEC (1 cycle): register i_resultado into result_q. Operands have been stable for at least one cycle, so the combinational ALU path has settled.
- SEND_LO: o_tx_data = result_q[7:0], pulse o_tx_start for 1 cycle, go to WAIT_LO. WAIT_LO waits for i_tx_done.
- SEND_HI: o_tx_data = {7'b0, result_q[8]}, pulse o_tx_start, go to WAIT_HI. WAIT_HI waits for i_tx_done, then returns to WAIT_A.
- SEND_ERR: pulse o_tx_start, go to WAIT_ERR. WAIT_ERR waits for i_tx_done, then returns to WAIT_A.
- Latency: the first o_tx_start occurs 2 cycles after the opcode i_rx_done (EXEC, then SEND_LO).
- o_tx_data holds its value from the o_tx_start cycle until the matching i_tx_done.
- o_dato_a, o_dato_b and o_op_code hold their values until overwritten by the next frame.
- Dropped bytes: i_rx_done in EXEC, SEND_*, WAIT_LO, WAIT_HI or WAIT_ERR discards the byte and sets o_overrun. o_overrun clears only on reset.
- Simultaneous i_rx_done and i_tx_done in a WAIT_* TX state: the state advances on i_tx_done and the byte is dropped with o_overrun.
- i_tx_done outside the WAIT_* TX states is ignored.
- Width rule: ADD/SUB results are 9-bit wrap. SUB borrow shows as bit 8 (e.g. 3-5 = 0x1FE).

Optional Feature:
- Macro: ALU_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every accepted byte and counts while in WAIT_B or WAIT_OP.
  - When the count reaches TIMEOUT_CYCLES-1, go to WAIT_A, pulse o_timeout and keep the operand registers.
  - The counter is held at 0 in all other states.
- Without the macro: WAIT_B and WAIT_OP wait indefinitely, o_timeout is tied to 0, and no counter logic exists.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD..OP_NOR, shared with alu_logic;
  - ERR_BYTE = 8'hEE;
  - state enumeration;
  - function is_valid_op().
- Sub-module alu_ctrl_timer (timeout counter, i_clk/i_reset/i_clear/i_run/o_expired), instantiated only under ALU_CTRL_TIMEOUT_EN.
- The FSM and datapath registers stay in alu_frame_ctrl.

Test Plan:
- RX 0x05, 0x03, 0x20 -> o_op_code = 0x20; TX bytes 0x08 then 0x00; o_error = 0.
- RX 0x03, 0x05, 0x22 -> TX 0xFE then 0x01 (borrow in bit 8).
- RX 0xF0, 0x0F, 0x3F -> o_error pulses once; TX single byte 0xEE; o_op_code unchanged; next frame 0x0C, 0x0A, 0x24 -> TX 0x08, 0x00.
- RX byte pulsed during WAIT_LO -> o_overrun = 1 and stays 1; the TX sequence completes unaffected; reset clears o_overrun.
- i_reset asserted for 1 cycle after RX 0xAA (state WAIT_B) -> all outputs 0 next cycle; RX 0x01, 0x01, 0x20 -> TX 0x02, 0x00.
- With ALU_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES = 16: RX 0x11 then idle 16 cycles -> o_timeout pulses; next 3 bytes parse as a fresh frame.
